// File: rtl/dpd_fex_pack.sv
// Shared types and helpers for the DPD feature-extraction front end.
// States, default geometry and the unsigned saturation helper.
package dpd_fex_pack;

  typedef enum logic [1:0] {
    IDLE,
    SQRT,
    CUBE,
    EMIT
  } fex_state_t;

  localparam int FEX_DATA_W   = 14;
  localparam int FEX_MEM_TAPS = 6;
  localparam int FEX_INPUTS   = 14;
  localparam int FEX_PAR      = 3;
  localparam int NUM_BEATS    =
    (FEX_INPUTS + FEX_PAR - 1) / FEX_PAR;

  function automatic logic [63:0] sat_u(
    input logic [63:0] x,
    input int          w
  );
    logic [63:0] m;
    m = (64'd1 << (w - 1)) - 64'd1;
    return (x > m) ? m : x;
  endfunction

endpackage

// File: rtl/dpd_isqrt.sv
// Iterative non-restoring integer square root.
// One root bit per cycle; root = floor(sqrt(rad)).
module dpd_isqrt #(
  parameter int W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] rad,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   root
);

  localparam int RW = W + 3;
  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0]        d;
  logic signed [RW-1:0]  r;
  logic [W-1:0]          q;
  logic [CW-1:0]         cnt;

  logic signed [RW-1:0]  r_sh;
  logic signed [RW-1:0]  r_n;
  logic [W-1:0]          q_n;

  assign r_sh = $signed({r[RW-3:0], d[2*W-1 -: 2]});

  // Remainder sign selects add-back vs subtract; no restore step.
  assign r_n = r[RW-1]
    ? r_sh + $signed(RW'({q, 2'b11}))
    : r_sh - $signed(RW'({q, 2'b01}));

  assign q_n  = {q[W-2:0], ~r_n[RW-1]};
  assign root = q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d    <= '0;
      r    <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      d    <= rad;
      r    <= '0;
      q    <= '0;
      cnt  <= CW'(W);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      d   <= d << 2;
      r   <= r_n;
      q   <= q_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/dpd_feature_extract.sv
// DPD front end: I/Q delay line, |x| and |x|^3 features,
// emitted as PARALLEL_INPUTS-wide beats.
module dpd_feature_extract
  import dpd_fex_pack::*;
#(
  parameter int DATA_W          = FEX_DATA_W,
  parameter int MEM_TAPS        = FEX_MEM_TAPS,
  parameter int INPUTS_SIZE     = FEX_INPUTS,
  parameter int PARALLEL_INPUTS = FEX_PAR
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_i,
  input  logic [DATA_W-1:0]             in_q,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PARALLEL_INPUTS*DATA_W-1:0] out_data,
  output logic                          out_last
);

  localparam int NB   =
    (INPUTS_SIZE + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS;
  localparam int KW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW   = PARALLEL_INPUTS * DATA_W;
  localparam int FW   = NB * LW;
  localparam int FRAC = DATA_W - 1;

  if (INPUTS_SIZE != 2 * MEM_TAPS + 2) begin : g_bad_size
    $error("INPUTS_SIZE must equal 2*MEM_TAPS+2");
  end

  fex_state_t state_q, state_d;

  logic [MEM_TAPS-1:0][DATA_W-1:0] ti, tq;
  logic [2*DATA_W-1:0]             sumsq, sumsq_d;
  logic signed [2*DATA_W-1:0]      si, sq;
  logic [DATA_W-1:0]               mag, cube;
  logic [DATA_W-1:0]               mag_n, mag2_n, cube_n;
  logic [DATA_W-1:0]               root;
  logic [KW-1:0]                   k;
  logic                            sq_busy, sq_done;
  logic                            accept, last_beat;
  logic [FW-1:0]                   fv;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_beat = (k == KW'(NB - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && last_beat;

  assign si      = {{DATA_W{in_i[DATA_W-1]}}, in_i};
  assign sq      = {{DATA_W{in_q[DATA_W-1]}}, in_q};
  assign sumsq_d = si * si + sq * sq;

  assign mag_n  = DATA_W'(sat_u(64'(root), DATA_W));
  assign mag2_n = DATA_W'(sat_u(64'(sumsq >> FRAC), DATA_W));
  assign cube_n = DATA_W'(sat_u(
    (64'(mag2_n) * 64'(mag_n)) >> FRAC, DATA_W));

  dpd_isqrt #(
    .W(DATA_W)
  ) u_isqrt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept),
    .rad  (sumsq_d),
    .busy (sq_busy),
    .done (sq_done),
    .root (root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = SQRT;
      SQRT: if (sq_done && !sq_busy) state_d = CUBE;
      CUBE: state_d = EMIT;
      EMIT: if (out_ready && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ti    <= '0;
      tq    <= '0;
      sumsq <= '0;
      mag   <= '0;
      cube  <= '0;
      k     <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (flush) begin
          ti <= '0;
          tq <= '0;
        end
        if (in_valid) begin
          // Flush with a sample: clear first, sample lands in tap 0.
          if (flush) begin
            ti[0] <= in_i;
            tq[0] <= in_q;
          end else begin
            ti <= {ti[MEM_TAPS-2:0], in_i};
            tq <= {tq[MEM_TAPS-2:0], in_q};
          end
          sumsq <= sumsq_d;
          k     <= '0;
        end
      end
      if (state_q == CUBE) begin
        mag  <= mag_n;
        cube <= cube_n;
      end
      if ((state_q == EMIT) && out_ready) begin
        k <= last_beat ? '0 : k + KW'(1);
      end
    end
  end

  always_comb begin
    fv = '0;
    fv[0 +: DATA_W]      = mag;
    fv[DATA_W +: DATA_W] = cube;
    for (int t = 0; t < MEM_TAPS; t++) begin
      fv[(2 + 2 * t) * DATA_W +: DATA_W] = ti[t];
      fv[(3 + 2 * t) * DATA_W +: DATA_W] = tq[t];
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == EMIT) begin
      for (int b = 0; b < NB; b++) begin
        if (k == KW'(b)) out_data = fv[b * LW +: LW];
      end
    end
  end

endmodule

// File: tb/tb_dpd_feature_extract.sv
// Bench for dpd_feature_extract: directed and random samples
// checked against an arithmetic reference of the feature vector.
module tb_dpd_feature_extract;

  localparam int W    = 14;
  localparam int TAPS = 6;
  localparam int P    = 3;
  localparam int NB   = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   in_i = '0;
  logic [W-1:0]   in_q = '0;
  logic           in_ready;
  logic           out_valid;
  logic           out_last;
  logic [P*W-1:0] out_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hi[TAPS];
  int hq[TAPS];
  int feat[NB*P];
  logic [P*W-1:0] got[NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dpd_feature_extract dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_i     (in_i),
    .in_q     (in_q),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt_ref(longint s);
    longint lo, hb, mid;
    lo = 0;
    hb = 65536;
    while (lo < hb) begin
      mid = (lo + hb + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hb = mid - 1;
    end
    return lo;
  endfunction

  function automatic int satv(longint x);
    return (x > 8191) ? 8191 : int'(x);
  endfunction

  task automatic model_clear();
    for (int t = 0; t < TAPS; t++) begin
      hi[t] = 0;
      hq[t] = 0;
    end
  endtask

  task automatic model_features();
    longint s;
    int m, m2, c;
    s  = longint'(hi[0]) * hi[0] + longint'(hq[0]) * hq[0];
    m  = satv(isqrt_ref(s));
    m2 = satv(s / 8192);
    c  = satv((longint'(m2) * m) / 8192);
    feat[0] = m;
    feat[1] = c;
    for (int t = 0; t < TAPS; t++) begin
      feat[2 + 2 * t] = hi[t];
      feat[3 + 2 * t] = hq[t];
    end
    feat[NB*P-1] = 0;
  endtask

  function automatic logic [P*W-1:0] exp_beat(int b);
    logic [P*W-1:0] v;
    v = '0;
    for (int j = 0; j < P; j++) v[j*W +: W] = W'(feat[b*P + j]);
    return v;
  endfunction

  task automatic send(int i, int q, bit fl);
    int n;
    in_i = W'(i);
    in_q = W'(q);
    in_valid = 1'b1;
    flush = fl;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    flush = 1'b0;
    if (fl) model_clear();
    for (int t = TAPS - 1; t > 0; t--) begin
      hi[t] = hi[t-1];
      hq[t] = hq[t-1];
    end
    hi[0] = i;
    hq[0] = q;
    model_features();
  endtask

  task automatic get_vec(string tag, int sb, int sl);
    int n;
    for (int b = 0; b < NB; b++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("%s_b%0d_valid", tag, b), 64'(out_valid), 64'd1);
      if (b == 0) chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd16);
      got[b] = out_data;
      chk($sformatf("%s_b%0d_data", tag, b), 64'(out_data),
          64'(exp_beat(b)));
      chk($sformatf("%s_b%0d_last", tag, b), 64'(out_last),
          64'(b == NB - 1));
      if (b == sb) begin
        out_ready = 1'b0;
        for (int s = 0; s < sl; s++) begin
          @(posedge clk); #1;
          chk($sformatf("%s_hold%0d", tag, s),
              {out_data, out_valid, in_ready},
              {exp_beat(b), 1'b1, 1'b0});
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_done_idle"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int ri, rq, seen;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_data, out_valid, out_last, in_ready},
        {42'd0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(4096, 0, 1'b0);
    get_vec("t1", NB, 0);
    chk("t1_beat0", 64'(got[0]), {22'd0, 14'd4096, 14'd1024, 14'd4096});

    send(3000, 4000, 1'b0);
    get_vec("t2", NB, 0);
    chk("t2_mag", 64'(got[0][0 +: W]), 64'd5000);
    chk("t2_cube", 64'(got[0][W +: W]), 64'd1862);
    chk("t2_q", 64'(got[1][0 +: W]), 64'd4000);

    send(-8192, -8192, 1'b0);
    get_vec("t3", NB, 0);
    chk("t3_mag", 64'(got[0][0 +: W]), 64'd8191);
    chk("t3_i", 64'(got[0][2*W +: W]), 64'h2000);

    for (int s = 1; s <= 7; s++) begin
      send(s * 100, s * 100, 1'b0);
      get_vec($sformatf("t4s%0d", s), NB, 0);
    end
    chk("t4_oldest", 64'(got[4]), {22'd0, 14'd0, 14'd200, 14'd200});

    send(int'($urandom_range(0, 16383)) - 8192,
         int'($urandom_range(0, 16383)) - 8192, 1'b0);
    get_vec("t5", 2, 10);

    send(1234, -2345, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
    #1;
    chk("t6_rst", {out_data, out_valid, out_last, in_ready},
        {42'd0, 1'b0, 1'b0, 1'b1});
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || out_last) seen++;
    end
    chk("t6_no_output", 64'(seen), 64'd0);
    send(0, 0, 1'b0);
    get_vec("t6_zero", NB, 0);

    for (int r = 0; r < 6; r++) begin
      ri = int'($urandom_range(0, 16383)) - 8192;
      rq = int'($urandom_range(0, 16383)) - 8192;
      send(ri, rq, 1'b0);
      get_vec($sformatf("rnd%0d", r), int'($urandom_range(0, NB)),
              int'($urandom_range(1, 4)));
    end

    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    chk("flush_idle", 64'(in_ready), 64'd1);
    send(777, -555, 1'b0);
    get_vec("flush", NB, 0);
    send(-1000, 2000, 1'b0);
    get_vec("pre_fv", NB, 0);
    send(321, 123, 1'b1);
    get_vec("flush_valid", NB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
